// File: rtl/full_adder_unit.sv
// Registered, width-parameterised ripple-carry full adder: {co, sum} = a + b + ci.
// One cycle of latency, full throughput, no backpressure.
// Optional macro FULL_ADDER_UNIT_OVF_EN adds a registered two's-complement
// overflow output (ovf); when undefined the port and its logic are absent.
module full_adder_unit #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             out_valid
`ifdef FULL_ADDER_UNIT_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Ripple chain: c[0] is the carry-in, c[WIDTH] the carry-out.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;
    logic             out_valid_q, out_valid_d;
`ifdef FULL_ADDER_UNIT_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Chain of 1-bit full-adder cells.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < int'(WIDTH); i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    // Capture a fresh result only when the input is qualified; otherwise hold
    // so that undefined operands on idle cycles never reach the outputs.
    always_comb begin
        sum_d       = sum_q;
        co_d        = co_q;
        out_valid_d = in_valid;
`ifdef FULL_ADDER_UNIT_OVF_EN
        ovf_d       = ovf_q;
`endif
        if (in_valid) begin
            sum_d = s;
            co_d  = c[WIDTH];
`ifdef FULL_ADDER_UNIT_OVF_EN
            // Signed overflow: carry into the sign bit differs from carry out.
            ovf_d = c[WIDTH] ^ c[WIDTH-1];
`endif
        end
    end

    // Output register stage; reset wins over a same-cycle valid input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            co_q        <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef FULL_ADDER_UNIT_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            sum_q       <= sum_d;
            co_q        <= co_d;
            out_valid_q <= out_valid_d;
`ifdef FULL_ADDER_UNIT_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign sum       = sum_q;
    assign co        = co_q;
    assign out_valid = out_valid_q;
`ifdef FULL_ADDER_UNIT_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder_unit.sv
// Self-checking bench for full_adder_unit: a WIDTH=1 and a WIDTH=8 instance
// compared each cycle against an arithmetic reference model.
module tb_full_adder_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       v1, a1, b1, ci1;
    logic       v8, ci8;
    logic [7:0] a8, b8;

    logic       sum1, co1, ov1, ovf1_w;
    logic [7:0] sum8;
    logic       co8, ov8, ovf8_w;

    // Expected {out_valid, co, sum, ovf} per instance.
    logic [3:0]  e1;
    logic [10:0] e8;
    wire  [3:0]  obs1 = {ov1, co1, sum1, ovf1_w};
    wire  [10:0] obs8 = {ov8, co8, sum8, ovf8_w};

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    full_adder_unit #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .a         (a1),
        .b         (b1),
        .ci        (ci1),
        .in_valid  (v1),
        .sum       (sum1),
        .co        (co1),
        .out_valid (ov1)
`ifdef FULL_ADDER_UNIT_OVF_EN
        ,
        .ovf       (ovf1_w)
`endif
    );

    full_adder_unit #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .a         (a8),
        .b         (b8),
        .ci        (ci8),
        .in_valid  (v8),
        .sum       (sum8),
        .co        (co8),
        .out_valid (ov8)
`ifdef FULL_ADDER_UNIT_OVF_EN
        ,
        .ovf       (ovf8_w)
`endif
    );

`ifndef FULL_ADDER_UNIT_OVF_EN
    assign ovf1_w = 1'b0;
    assign ovf8_w = 1'b0;
`endif

    // Signed overflow: true signed sum falls outside the w-bit signed range.
    function automatic logic ovf_of(input int w, input longint ua, input longint ub,
                                    input longint c);
`ifdef FULL_ADDER_UNIT_OVF_EN
        longint full, sa, sb, r;
        full = longint'(1) << w;
        sa   = (ua >= full / 2) ? ua - full : ua;
        sb   = (ub >= full / 2) ? ub - full : ub;
        r    = sa + sb + c;
        return (r > full / 2 - 1) || (r < -(full / 2));
`else
        return 1'b0;
`endif
    endfunction

    // Reference model evaluated at each rising edge from the sampled inputs.
    task automatic model_edge();
        longint r;
        if (rst) begin
            e1 = '0;
            e8 = '0;
        end else begin
            if (v1) begin
                r  = longint'(a1) + longint'(b1) + longint'(ci1);
                e1 = {1'b1, r[1], r[0], ovf_of(1, longint'(a1), longint'(b1), longint'(ci1))};
            end else begin
                e1[3] = 1'b0;
            end
            if (v8) begin
                r  = longint'(a8) + longint'(b8) + longint'(ci8);
                e8 = {1'b1, r[8], r[7:0], ovf_of(8, longint'(a8), longint'(b8), longint'(ci8))};
            end else begin
                e8[10] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
        v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            tests++;
            if (obs1 !== 4'b0) begin
                fails++;
                $display("FAIL reset_w1 cyc%0d got %b expected 0000", k, obs1);
            end
            tests++;
            if (obs8 !== 11'b0) begin
                fails++;
                $display("FAIL reset_w8 cyc%0d got %h expected 000", k, obs8);
            end
        end
        rst = 1'b0;
        v1  = 1'b0;
        v8  = 1'b0;
    endtask

    // Directed corners then all 8 combinations back-to-back on the 1-bit adder.
    task automatic test_w1_exhaustive();
        logic [2:0] pats [12];
        logic [2:0] p;
        pats = '{3'b000, 3'b001, 3'b110, 3'b111,
                 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        for (int k = 0; k < 12; k++) begin
            p = pats[k];
            v1 = 1'b1; a1 = p[2]; b1 = p[1]; ci1 = p[0];
            tick();
            tests++;
            if (obs1 !== e1) begin
                fails++;
                $display("FAIL w1_add a=%b b=%b ci=%b got %b expected %b",
                         p[2], p[1], p[0], obs1, e1);
            end
        end
        v1 = 1'b0;
    endtask

    task automatic test_w8_directed();
        logic [16:0] vec [2];
        vec = '{{8'hFF, 8'h01, 1'b0}, {8'h7F, 8'h00, 1'b1}};
        for (int k = 0; k < 2; k++) begin
            v8 = 1'b1; a8 = vec[k][16:9]; b8 = vec[k][8:1]; ci8 = vec[k][0];
            tick();
            tests++;
            if (obs8 !== e8) begin
                fails++;
                $display("FAIL w8_directed a=%h b=%h ci=%b got %h expected %h",
                         a8, b8, ci8, obs8, e8);
            end
        end
        v8 = 1'b0;
    endtask

    // Idle cycles with defined and undefined operands must leave sum/co untouched.
    task automatic test_hold();
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; ci1 = 1'b0;
        v8 = 1'b1; a8 = 8'h12; b8 = 8'h34; ci8 = 1'b1;
        tick();
        tests++;
        if (obs1 !== 4'b1010 && obs1 !== 4'b1011) begin
            fails++;
            $display("FAIL hold_accept got %b expected 101x", obs1);
        end
        for (int k = 0; k < 3; k++) begin
            v1 = 1'b0; v8 = 1'b0;
            if (k == 0) begin
                a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
            end else begin
                a1 = 1'bx; b1 = 1'bx; ci1 = 1'bx; a8 = 'x; b8 = 'x; ci8 = 1'bx;
            end
            tick();
            tests++;
            if (obs1 !== e1) begin
                fails++;
                $display("FAIL hold_w1 cyc%0d got %b expected %b", k, obs1, e1);
            end
            tests++;
            if (obs8 !== e8) begin
                fails++;
                $display("FAIL hold_w8 cyc%0d got %h expected %h", k, obs8, e8);
            end
        end
    endtask

    task automatic test_reset_mid();
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
        v8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b0;
        tick();
        rst = 1'b1;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
        v8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; ci8 = 1'b1;
        tick();
        tests++;
        if (obs1 !== 4'b0) begin
            fails++;
            $display("FAIL reset_mid_w1 got %b expected 0000", obs1);
        end
        tests++;
        if (obs8 !== 11'b0) begin
            fails++;
            $display("FAIL reset_mid_w8 got %h expected 000", obs8);
        end
        rst = 1'b0;
        v1  = 1'b0;
        v8  = 1'b0;
    endtask

    task automatic test_back_to_back_random();
        for (int k = 0; k < 300; k++) begin
            rst = ($urandom_range(0, 29) == 0);
            v1  = ($urandom_range(0, 3) != 0);
            a1  = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
            v8  = ($urandom_range(0, 3) != 0);
            a8  = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
            tick();
            tests++;
            if (obs1 !== e1) begin
                fails++;
                $display("FAIL random_w1 cyc%0d got %b expected %b", k, obs1, e1);
            end
            tests++;
            if (obs8 !== e8) begin
                fails++;
                $display("FAIL random_w8 cyc%0d got %h expected %h", k, obs8, e8);
            end
        end
        rst = 1'b0;
        v1  = 1'b0;
        v8  = 1'b0;
    endtask

    initial begin
        e1 = '0;
        e8 = '0;
        test_reset();
        test_w1_exhaustive();
        test_w8_directed();
        test_hold();
        test_reset_mid();
        test_back_to_back_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/full_adder_unit.md
Name: full_adder_unit

Overview:
- Registered, width-parameterised full adder: a + b + ci -> {co, sum}.
- Built as a ripple chain of 1-bit full-adder cells feeding one output register stage.
- Default WIDTH=1 gives the classic single-bit full adder with one cycle of latency.
- Used as a leaf arithmetic block in datapaths that need a clean registered carry-out.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- ci  input  1  carry-in
- in_valid  input  1  qualifies a/b/ci this cycle
- sum  output  WIDTH  registered sum bits
- co  output  1  registered carry-out (MSB of the WIDTH+1-bit result)
- out_valid  output  1  sum/co hold a fresh result

Behaviour:
- Combinational ripple: c[0]=ci; for i in 0..WIDTH-1: s[i]=a[i]^b[i]^c[i], c[i+1]=(a[i]&b[i])|(c[i]&(a[i]^b[i])); co_next=c[WIDTH].
- Arithmetic is exact: {co,sum} == a + b + ci as a WIDTH+1-bit unsigned value; no saturation, modulo 2^(WIDTH+1) never needed.
- Latency is exactly 1 clk: values sampled on edge N appear on sum/co/out_valid after edge N.
- in_valid=1: register captures sum/co; out_valid<=1 next cycle.
- in_valid=0: sum/co hold previous value; out_valid<=0. No backpressure; a result is presented for one cycle per accepted input.
- Back-to-back in_valid=1 supported: one result per cycle, full throughput.
- Reset (rst=1 at a rising edge): sum<=0, co<=0, out_valid<=0; overrides in_valid in the same cycle. Reset mid-stream discards the in-flight result.
- X/undefined inputs while in_valid=0 must not disturb outputs.
- No internal state beyond the output register (and optional overflow flag).

Optional Feature:
- Macro FULL_ADDER_UNIT_OVF_EN.
- Defined: extra output port ovf (1 bit, registered with sum) = c[WIDTH] ^ c[WIDTH-1], i.e. two's-complement signed overflow; for WIDTH=1, ovf = c[1] ^ ci. Resets to 0 and holds when in_valid=0, same as co.
- Not defined: port ovf absent; no overflow logic synthesised.

Test Plan:
- WIDTH=1, rst high 2 cycles then low -> sum=0, co=0, out_valid=0 throughout reset.
- WIDTH=1, in_valid=1: (a,b,ci)=(0,0,0) -> next cycle sum=0, co=0; (0,0,1) -> sum=1, co=0; (1,1,0) -> sum=0, co=1; (1,1,1) -> sum=1, co=1.
- WIDTH=1, exhaustive 8 input combinations back-to-back -> each result one cycle later, out_valid=1 every cycle, {co,sum}=a+b+ci.
- WIDTH=8: a=8'hFF, b=8'h01, ci=0 -> sum=8'h00, co=1; a=8'h7F, b=8'h00, ci=1 -> sum=8'h80, co=0 (ovf=1 with FULL_ADDER_UNIT_OVF_EN).
- Hold: accept (1,0,0) -> sum=1; then in_valid=0 with a=1,b=1 -> sum stays 1, co stays 0, out_valid=0.
- Reset mid-stream: in_valid=1 with (1,1,1) and rst=1 same edge -> sum=0, co=0, out_valid=0 next cycle.
